// File: rtl/me_pkg.sv
// Shared definitions for the reference-row scheduler: geometry defaults and FSM encoding.
package me_pkg;

    localparam int unsigned PIXEL_DEF = 8;
    localparam int unsigned COLS_DEF  = 32;
    localparam int unsigned ROWS_DEF  = 8;
    localparam int unsigned OU_CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Row index width; kept at least one bit so a single-row OU still has a legal port.
    function automatic int unsigned idx_w(input int unsigned rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

endpackage

// File: rtl/row_sep.sv
// Combinational slicer: splits a packed OU into per-row vectors, row k (1-based) from the k-th slice.
module row_sep
    import me_pkg::*;
#(
    parameter int unsigned ROW_W = PIXEL_DEF * COLS_DEF,
    parameter int unsigned ROWS  = ROWS_DEF
) (
    input  logic [ROWS*ROW_W-1:0]       ref_ou,
    output logic [ROWS-1:0][ROW_W-1:0]  rows
);

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        assign rows[r] = ref_ou[r*ROW_W +: ROW_W];
    end

endmodule

// File: rtl/ref_row_sched.sv
// Reference-row scheduler: accepts whole OUs and issues their rows one per handshake in a
// configurable scan direction, counting OUs until the configured pass length is reached.
module ref_row_sched
    import me_pkg::*;
#(
    parameter int unsigned PIXEL = PIXEL_DEF,
    parameter int unsigned COLS  = COLS_DEF,
    parameter int unsigned ROWS  = ROWS_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        cfg_dir,
    input  logic [3:0]                  cfg_num_ou,
    input  logic                        ou_valid,
    output logic                        ou_ready,
    input  logic [ROWS*COLS*PIXEL-1:0]  ref_ou,
    output logic                        row_valid,
    input  logic                        row_ready,
    output logic [COLS*PIXEL-1:0]       row_data,
    output logic [idx_w(ROWS)-1:0]      row_idx,
    output logic                        row_last,
    output logic                        pass_last,
    output logic                        busy,
    output logic                        done
);

    localparam int unsigned ROW_W = COLS * PIXEL;
    localparam int unsigned IDX_W = idx_w(ROWS);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(ROWS - 1);

    state_t                      state_q, state_d;
    logic                        dir_q;
    logic [OU_CNT_W-1:0]         num_ou_q;
    logic [OU_CNT_W-1:0]         ou_cnt_q;
    logic [IDX_W-1:0]            ptr_q;
    logic [ROWS-1:0][ROW_W-1:0]  buf_q;
    logic [ROWS-1:0][ROW_W-1:0]  rows_in;
    logic                        ou_hs;
    logic                        row_hs;
    logic                        at_last;
    logic                        ou_final;

    row_sep #(
        .ROW_W (ROW_W),
        .ROWS  (ROWS)
    ) u_row_sep (
        .ref_ou (ref_ou),
        .rows   (rows_in)
    );

    assign at_last  = dir_q ? (ptr_q == '0) : (ptr_q == IDX_MAX);
    assign ou_final = (OU_CNT_W'(ou_cnt_q + 1'b1) == num_ou_q);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake decode
    always_comb begin
        state_d = state_q;
        ou_hs   = 1'b0;
        row_hs  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (cfg_num_ou == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                ou_hs = ou_valid;
                if (ou_valid) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                row_hs = row_ready;
                if (row_ready && at_last) begin
                    state_d = ou_final ? ST_DONE : ST_LOAD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status flags registered from the next state so they line up with state_q
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ou_ready  <= 1'b0;
            row_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            ou_ready  <= (state_d == ST_LOAD);
            row_valid <= (state_d == ST_ISSUE);
            busy      <= (state_d != ST_IDLE);
            done      <= (state_d == ST_DONE);
        end
    end

    // Config latch, OU buffer (written only while loading), row pointer and OU counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_q    <= 1'b0;
            num_ou_q <= '0;
            ou_cnt_q <= '0;
            ptr_q    <= '0;
            buf_q    <= '0;
        end else begin
            if (state_q == ST_IDLE && start) begin
                dir_q    <= cfg_dir;
                num_ou_q <= cfg_num_ou;
                ou_cnt_q <= '0;
            end
            if (ou_hs) begin
                buf_q <= rows_in;
                ptr_q <= dir_q ? IDX_MAX : '0;
            end
            if (row_hs) begin
                if (at_last) begin
                    ou_cnt_q <= OU_CNT_W'(ou_cnt_q + 1'b1);
                end else begin
                    ptr_q <= dir_q ? IDX_W'(ptr_q - 1'b1) : IDX_W'(ptr_q + 1'b1);
                end
            end
        end
    end

    assign row_data  = buf_q[ptr_q];
    assign row_idx   = ptr_q;
    assign row_last  = row_valid & at_last;
    assign pass_last = row_last & ou_final;

endmodule

// File: tb/tb_ref_row_sched.sv
// Self-checking bench for ref_row_sched: pass/OU/row-level reference model plus directed passes.
module tb_ref_row_sched;

    localparam int unsigned PIXEL = 8;
    localparam int unsigned COLS  = 32;
    localparam int unsigned ROWS  = 8;
    localparam int unsigned ROW_W = COLS * PIXEL;
    localparam int unsigned OU_W  = ROWS * ROW_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              cfg_dir;
    logic [3:0]        cfg_num_ou;
    logic              ou_valid;
    logic              ou_ready;
    logic [OU_W-1:0]   ref_ou;
    logic              row_valid;
    logic              row_ready;
    logic [ROW_W-1:0]  row_data;
    logic [2:0]        row_idx;
    logic              row_last;
    logic              pass_last;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ref_row_sched #(
        .PIXEL (PIXEL),
        .COLS  (COLS),
        .ROWS  (ROWS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_dir    (cfg_dir),
        .cfg_num_ou (cfg_num_ou),
        .ou_valid   (ou_valid),
        .ou_ready   (ou_ready),
        .ref_ou     (ref_ou),
        .row_valid  (row_valid),
        .row_ready  (row_ready),
        .row_data   (row_data),
        .row_idx    (row_idx),
        .row_last   (row_last),
        .pass_last  (pass_last),
        .busy       (busy),
        .done       (done)
    );

    task automatic chk(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Row k (1-based) of an OU: every pixel equals base + k
    function automatic logic [OU_W-1:0] make_ou(input logic [7:0] base);
        logic [OU_W-1:0] v;
        v = '0;
        for (int k = 0; k < ROWS; k++) begin
            for (int c = 0; c < COLS; c++) begin
                v[(k*COLS + c)*PIXEL +: PIXEL] = 8'(base + 8'(k + 1));
            end
        end
        return v;
    endfunction

    // Reference model: pass phase (0 idle, 1 running, 2 done cycle) and a queue of rows owed downstream
    typedef struct {
        logic [ROW_W-1:0] data;
        logic [2:0]       idx;
        logic             last;
        logic             pl;
    } exp_t;

    exp_t exp_q[$];
    int   m_phase   = 0;
    logic m_dir     = 1'b0;
    int   m_num     = 0;
    int   m_ou_seen = 0;

    always @(negedge clk) begin
        exp_t e;
        int   nxt;
        logic exp_rdy;
        if (rst) begin
            exp_q.delete();
            m_phase = 0;
            chk("rst_outputs_zero",
                ROW_W'({ou_ready, row_valid, row_last, pass_last, busy, done, |row_data, |row_idx}), '0);
        end else begin
            nxt     = m_phase;
            exp_rdy = (m_phase == 1) && (exp_q.size() == 0) && (m_ou_seen < m_num);
            chk("busy", ROW_W'(busy), ROW_W'(m_phase != 0));
            chk("done", ROW_W'(done), ROW_W'(m_phase == 2));
            chk("row_valid", ROW_W'(row_valid), ROW_W'(exp_q.size() != 0));
            chk("ou_ready", ROW_W'(ou_ready), ROW_W'(exp_rdy));
            if (row_valid && exp_q.size() != 0) begin
                e = exp_q[0];
                chk("row_data", row_data, e.data);
                chk("row_idx", ROW_W'(row_idx), ROW_W'(e.idx));
                chk("row_last", ROW_W'(row_last), ROW_W'(e.last));
                chk("pass_last", ROW_W'(pass_last), ROW_W'(e.pl));
                if (row_ready) begin
                    void'(exp_q.pop_front());
                    if (e.pl) nxt = 2;
                end
            end else begin
                chk("flags_without_row", ROW_W'(row_last | pass_last), '0);
            end
            if (exp_rdy && ou_valid) begin
                m_ou_seen++;
                for (int r = 0; r < ROWS; r++) begin
                    e.idx  = m_dir ? 3'(ROWS - 1 - r) : 3'(r);
                    e.data = ref_ou[int'(e.idx)*ROW_W +: ROW_W];
                    e.last = (r == ROWS - 1);
                    e.pl   = e.last && (m_ou_seen == m_num);
                    exp_q.push_back(e);
                end
            end
            if (m_phase == 0 && start) begin
                m_dir     = cfg_dir;
                m_num     = int'(cfg_num_ou);
                m_ou_seen = 0;
                nxt       = (cfg_num_ou == 4'd0) ? 2 : 1;
            end else if (m_phase == 2) begin
                nxt = 0;
            end
            m_phase = nxt;
        end
    end

    int         res_rows, res_lasts, res_pls, res_ourdy, res_dones, res_done_cyc, res_last_idx;
    int         seen_idx[$];
    logic [7:0] seen_b0[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic dir, input logic [3:0] n);
        cfg_dir    = dir;
        cfg_num_ou = n;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic run_pass(input logic dir, input logic [3:0] n, input logic [7:0] base,
                            input int stall_idx, input int stall_len, input bit stray,
                            input int abort_ou);
        int   ou_cnt_drv;
        int   stall_cnt;
        bit   finished;
        bit   aborted;
        logic accepted;
        ou_cnt_drv = 0; stall_cnt = 0; finished = 0; aborted = 0;
        res_rows = 0; res_lasts = 0; res_pls = 0; res_ourdy = 0; res_dones = 0;
        res_done_cyc = -1; res_last_idx = -1;
        seen_idx.delete(); seen_b0.delete();
        ref_ou    = make_ou(base);
        ou_valid  = 1'b1;
        row_ready = 1'b1;
        do_start(dir, n);
        for (int cyc = 0; cyc < 400; cyc++) begin
            row_ready = 1'b1;
            if (row_valid && int'(row_idx) == stall_idx && ou_cnt_drv == 1 && stall_cnt < stall_len) begin
                row_ready = 1'b0;
                stall_cnt++;
            end
            start = stray && (cyc == 5);
            cfg_num_ou = start ? 4'd1 : n;
            cfg_dir    = start ? ~dir : dir;
            if (abort_ou != 0 && ou_cnt_drv == abort_ou && row_valid && int'(row_idx) == 5) begin
                rst = 1'b1;
                #1;
                chk("rst_async_zero",
                    ROW_W'({ou_ready, row_valid, row_last, pass_last, busy, done, |row_data, |row_idx}), '0);
                tick();
                tick();
                rst = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    chk("no_done_after_rst", ROW_W'({done, busy}), '0);
                    tick();
                end
                aborted = 1;
                break;
            end
            if (ou_ready) res_ourdy++;
            if (row_valid && row_ready) begin
                res_rows++;
                seen_idx.push_back(int'(row_idx));
                seen_b0.push_back(row_data[7:0]);
                if (row_last) begin
                    res_lasts++;
                    res_last_idx = int'(row_idx);
                end
                if (pass_last) res_pls++;
            end
            if (done) begin
                res_dones++;
                res_done_cyc = cyc;
                finished = 1;
            end
            accepted = ou_ready && ou_valid;
            tick();
            if (accepted) begin
                ou_cnt_drv++;
                ref_ou = make_ou(8'(base + 8'(16 * ou_cnt_drv)));
            end
            if (finished) break;
        end
        start    = 1'b0;
        ou_valid = 1'b0;
        if (!aborted) begin
            chk("pass_finished", ROW_W'(finished), ROW_W'(1));
            chk("done_single_cycle", ROW_W'({done, busy}), '0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cfg_dir = 1'b0; cfg_num_ou = 4'd0;
        ou_valid = 1'b0; ref_ou = '0; row_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // One OU, forward scan
        run_pass(1'b0, 4'd1, 8'h00, -1, 0, 1'b0, 0);
        chk("t1_rows", ROW_W'(res_rows), ROW_W'(8));
        chk("t1_ou_ready_cycles", ROW_W'(res_ourdy), ROW_W'(1));
        chk("t1_first_idx", ROW_W'(seen_idx[0]), ROW_W'(0));
        chk("t1_last_seen_idx", ROW_W'(seen_idx[7]), ROW_W'(7));
        chk("t1_first_byte", ROW_W'(seen_b0[0]), ROW_W'(8'h01));
        chk("t1_last_byte", ROW_W'(seen_b0[7]), ROW_W'(8'h08));
        chk("t1_row_last_idx", ROW_W'(res_last_idx), ROW_W'(7));
        chk("t1_pass_last_count", ROW_W'(res_pls), ROW_W'(1));
        chk("t1_done_cycle", ROW_W'(res_done_cyc), ROW_W'(9));

        // Same OU, reverse scan
        run_pass(1'b1, 4'd1, 8'h00, -1, 0, 1'b0, 0);
        chk("t2_first_idx", ROW_W'(seen_idx[0]), ROW_W'(7));
        chk("t2_last_seen_idx", ROW_W'(seen_idx[7]), ROW_W'(0));
        chk("t2_first_byte", ROW_W'(seen_b0[0]), ROW_W'(8'h08));
        chk("t2_last_byte", ROW_W'(seen_b0[7]), ROW_W'(8'h01));
        chk("t2_row_last_idx", ROW_W'(res_last_idx), ROW_W'(0));
        chk("t2_done_cycle", ROW_W'(res_done_cyc), ROW_W'(9));

        // Three OUs back to back, with a stray start mid-pass that must be ignored
        run_pass(1'b0, 4'd3, 8'h10, -1, 0, 1'b1, 0);
        chk("t3_rows", ROW_W'(res_rows), ROW_W'(24));
        chk("t3_row_last_count", ROW_W'(res_lasts), ROW_W'(3));
        chk("t3_pass_last_count", ROW_W'(res_pls), ROW_W'(1));
        chk("t3_ou_ready_cycles", ROW_W'(res_ourdy), ROW_W'(3));
        chk("t3_ou2_first_byte", ROW_W'(seen_b0[8]), ROW_W'(8'h21));
        chk("t3_ou3_last_byte", ROW_W'(seen_b0[23]), ROW_W'(8'h38));
        chk("t3_done_cycle", ROW_W'(res_done_cyc), ROW_W'(27));

        // Downstream stall of 4 cycles at idx 3
        run_pass(1'b0, 4'd1, 8'h40, 3, 4, 1'b0, 0);
        chk("t4_rows", ROW_W'(res_rows), ROW_W'(8));
        chk("t4_idx3", ROW_W'(seen_idx[3]), ROW_W'(3));
        chk("t4_idx4", ROW_W'(seen_idx[4]), ROW_W'(4));
        chk("t4_byte4", ROW_W'(seen_b0[4]), ROW_W'(8'h45));
        chk("t4_done_cycle", ROW_W'(res_done_cyc), ROW_W'(13));

        // Empty pass
        run_pass(1'b0, 4'd0, 8'h00, -1, 0, 1'b0, 0);
        chk("t5_rows", ROW_W'(res_rows), ROW_W'(0));
        chk("t5_ou_ready_cycles", ROW_W'(res_ourdy), ROW_W'(0));
        chk("t5_done_count", ROW_W'(res_dones), ROW_W'(1));
        chk("t5_done_cycle", ROW_W'(res_done_cyc), ROW_W'(0));

        // Reset at idx 5 of OU 2, then a fresh single-OU pass
        run_pass(1'b0, 4'd3, 8'h50, -1, 0, 1'b0, 2);
        chk("t6_rows_before_rst", ROW_W'(res_rows), ROW_W'(13));
        chk("t6_no_done", ROW_W'(res_dones), ROW_W'(0));
        run_pass(1'b0, 4'd1, 8'h60, -1, 0, 1'b0, 0);
        chk("t6_rows_after", ROW_W'(res_rows), ROW_W'(8));
        chk("t6_first_byte_after", ROW_W'(seen_b0[0]), ROW_W'(8'h61));
        chk("t6_done_cycle_after", ROW_W'(res_done_cyc), ROW_W'(9));

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
